// File: rtl/lsu_ctrl_if.sv
// Bundle of the pipeline-side request/response signals and the data-bus
// signals of the load/store sequencer. clk and reset stay plain ports.
interface lsu_ctrl_if;
    // pipeline request side
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [1:0]  i_length;
    logic        i_signed;
    // pipeline response side
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_fault;
    logic [1:0]  o_fault_cause;
    // data bus side
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_we;
    logic        o_bus_stb;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    // the sequencer itself
    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_length, i_signed, i_bus_ack, i_bus_rdata,
        output o_busy, o_done, o_rdata, o_fault, o_fault_cause,
        output o_bus_addr, o_bus_wdata, o_bus_we, o_bus_stb
    );

    // the pipeline stage plus bus slave driving the sequencer
    modport master (
        output i_req, i_we, i_addr, i_wdata, i_length, i_signed, i_bus_ack, i_bus_rdata,
        input  o_busy, o_done, o_rdata, o_fault, o_fault_cause,
        input  o_bus_addr, o_bus_wdata, o_bus_we, o_bus_stb
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: checks alignment, formats store lanes and byte
// enables, runs one strobe/ack bus transaction with timeout and returns a
// lane-aligned, optionally sign-extended load result with a done pulse.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    lsu_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_ILLLEN  = 2'b11;

    // Data mask for an access length (byte / half / word).
    function automatic logic [31:0] len_mask(input logic [1:0] len);
        logic [31:0] m;
        case (len)
            2'b00:   m = 32'h0000_00FF;
            2'b01:   m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    // Rotate left by whole bytes: moves byte 0 up to lane s.
    function automatic logic [31:0] rotl8(input logic [31:0] d, input logic [1:0] s);
        logic [31:0] r;
        case (s)
            2'd0:    r = d;
            2'd1:    r = {d[23:0], d[31:24]};
            2'd2:    r = {d[15:0], d[31:16]};
            default: r = {d[7:0],  d[31:8]};
        endcase
        return r;
    endfunction

    // Rotate right by whole bytes: brings lane s down to byte 0.
    function automatic logic [31:0] rotr8(input logic [31:0] d, input logic [1:0] s);
        logic [31:0] r;
        case (s)
            2'd0:    r = d;
            2'd1:    r = {d[7:0],  d[31:8]};
            2'd2:    r = {d[15:0], d[31:16]};
            default: r = {d[23:0], d[31:24]};
        endcase
        return r;
    endfunction

    // Byte-lane write enables for an access of length len at offset s.
    function automatic logic [3:0] byte_en(input logic [1:0] len, input logic [1:0] s);
        logic [3:0] b;
        case (len)
            2'b00:   b = 4'b0001;
            2'b01:   b = 4'b0011;
            default: b = 4'b1111;
        endcase
        return b << s;
    endfunction

    // Align, mask and optionally sign-extend returned load data.
    function automatic logic [31:0] load_fmt(input logic [31:0] d, input logic [1:0] len,
                                             input logic [1:0] s, input logic sgn);
        logic [31:0] r;
        r = rotr8(d, s) & len_mask(len);
        if (sgn && (len == 2'b00)) begin
            r[31:8] = {24{r[7]}};
        end else if (sgn && (len == 2'b01)) begin
            r[31:16] = {16{r[15]}};
        end else begin
            r = r;
        end
        return r;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [1:0]       ofs_q, ofs_d;
    logic [1:0]       len_q, len_d;
    logic             sgn_q, sgn_d;
    logic             done_q, done_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             fault_q, fault_d;
    logic [1:0]       cause_q, cause_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_we_q, bus_we_d;
    logic             bus_stb_q, bus_stb_d;

    logic             misaligned_s;
    logic             timeout_hit_s;

    assign misaligned_s  = ((bus.i_length == 2'b01) && bus.i_addr[0]) ||
                           ((bus.i_length == 2'b10) && (bus.i_addr[1:0] != 2'b00));
    assign timeout_hit_s = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state and output-register computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        ofs_d       = ofs_q;
        len_d       = len_q;
        sgn_d       = sgn_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        fault_d     = 1'b0;
        cause_d     = CAUSE_NONE;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        bus_stb_d   = bus_stb_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_req) begin
                    if (bus.i_length == 2'b11) begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        cause_d = CAUSE_ILLLEN;
                        rdata_d = 32'h0;
                    end else if (misaligned_s) begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        cause_d = CAUSE_MISALGN;
                        rdata_d = 32'h0;
                    end else begin
                        state_d     = ST_BUS;
                        cnt_d       = '0;
                        we_d        = bus.i_we;
                        ofs_d       = bus.i_addr[1:0];
                        len_d       = bus.i_length;
                        sgn_d       = bus.i_signed;
                        bus_stb_d   = 1'b1;
                        bus_addr_d  = {bus.i_addr[31:2], 2'b00};
                        bus_we_d    = bus.i_we ? byte_en(bus.i_length, bus.i_addr[1:0]) : 4'b0000;
                        bus_wdata_d = bus.i_we ?
                                      rotl8(bus.i_wdata & len_mask(bus.i_length), bus.i_addr[1:0]) :
                                      32'h0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (bus.i_bus_ack) begin
                    state_d     = ST_RESP;
                    done_d      = 1'b1;
                    rdata_d     = we_q ? 32'h0 : load_fmt(bus.i_bus_rdata, len_q, ofs_q, sgn_q);
                    bus_stb_d   = 1'b0;
                    bus_addr_d  = 32'h0;
                    bus_we_d    = 4'b0000;
                    bus_wdata_d = 32'h0;
                end else if (timeout_hit_s) begin
                    state_d     = ST_RESP;
                    done_d      = 1'b1;
                    fault_d     = 1'b1;
                    cause_d     = CAUSE_TIMEOUT;
                    rdata_d     = 32'h0;
                    bus_stb_d   = 1'b0;
                    bus_addr_d  = 32'h0;
                    bus_we_d    = 4'b0000;
                    bus_wdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_stb_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            ofs_q       <= 2'b00;
            len_q       <= 2'b00;
            sgn_q       <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= 32'h0;
            fault_q     <= 1'b0;
            cause_q     <= 2'b00;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_we_q    <= 4'b0000;
            bus_stb_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            ofs_q       <= ofs_d;
            len_q       <= len_d;
            sgn_q       <= sgn_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            bus_stb_q   <= bus_stb_d;
        end
    end

    // Stall must react to a new request in the same cycle, so it is not registered.
    assign bus.o_busy        = ((state_q == ST_IDLE) && bus.i_req) || (state_q == ST_BUS);
    assign bus.o_done        = done_q;
    assign bus.o_rdata       = rdata_q;
    assign bus.o_fault       = fault_q;
    assign bus.o_fault_cause = cause_q;
    assign bus.o_bus_addr    = bus_addr_q;
    assign bus.o_bus_wdata   = bus_wdata_q;
    assign bus.o_bus_we      = bus_we_q;
    assign bus.o_bus_stb     = bus_stb_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed table, reset/back-to-back
// sequences, and random accesses checked against a byte-level model.
module tb_lsu_ctrl;

    localparam int TO = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  len;
        logic        sgn;
        int          ack_at;     // stb cycle (1-based) on which ack is given; 0 = never
        logic [31:0] brd;
        logic [1:0]  exp_cause;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [31:0] last_rdata;
    vec_t tbl[14];

    lsu_ctrl_if bus_if();

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expectations from the access rules, byte by byte.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        logic [1:0]  s;
        int          nb;
        logic [31:0] m;
        logic [31:0] ld;
        r  = v;
        s  = v.addr[1:0];
        nb = 1 << v.len;
        if (v.len == 2'b11)
            r.exp_cause = 2'b11;
        else if ((v.len == 2'b01 && v.addr[0]) || (v.len == 2'b10 && s != 2'b00))
            r.exp_cause = 2'b01;
        else if (v.ack_at < 1 || v.ack_at > TO)
            r.exp_cause = 2'b10;
        else
            r.exp_cause = 2'b00;
        m = (nb >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        r.exp_we    = 4'b0000;
        r.exp_wdata = 32'h0;
        if (v.we) begin
            for (int b = 0; b < nb; b++) begin
                r.exp_we[(b + s) % 4]              = 1'b1;
                r.exp_wdata[8*((b + s) % 4) +: 8] = v.wdata[8*b +: 8];
            end
        end
        ld = 32'h0;
        for (int b = 0; b < 4; b++) ld[8*b +: 8] = v.brd[8*((b + s) % 4) +: 8];
        ld = ld & m;
        if (v.sgn && nb == 1 && ld[7])  ld = ld | 32'hFFFF_FF00;
        if (v.sgn && nb == 2 && ld[15]) ld = ld | 32'hFFFF_0000;
        r.exp_rdata = (v.we || r.exp_cause != 2'b00) ? 32'h0 : ld;
        return r;
    endfunction

    // One complete access, acting as pipeline and bus slave, checked every cycle.
    task automatic run_access(input vec_t v, input bit chained, input bit keep_req);
        int  L;
        int  done_n;
        bit  reqfault;
        reqfault = (v.exp_cause == 2'b01) || (v.exp_cause == 2'b11);
        L = reqfault ? 0 : ((v.ack_at >= 1 && v.ack_at <= TO) ? v.ack_at : TO);
        done_n = L + 1;
        if (!chained) @(negedge clk);
        bus_if.i_req       = 1'b1;
        bus_if.i_we        = v.we;
        bus_if.i_addr      = v.addr;
        bus_if.i_wdata     = v.wdata;
        bus_if.i_length    = v.len;
        bus_if.i_signed    = v.sgn;
        bus_if.i_bus_ack   = 1'b0;
        bus_if.i_bus_rdata = v.brd;
        if (chained) begin
            #1 chk("busy_resp", bus_if.o_busy, 1'b0);
            @(negedge clk);
            chk("stb_gap", bus_if.o_bus_stb, 1'b0);
        end
        #1 chk("busy_req", bus_if.o_busy, 1'b1);
        for (int n = 1; n <= done_n; n++) begin
            @(negedge clk);
            chk("stb", bus_if.o_bus_stb, (n <= L));
            if (n <= L) begin
                chk("bus_addr", bus_if.o_bus_addr, v.addr & 32'hFFFF_FFFC);
                chk("bus_we", bus_if.o_bus_we, v.exp_we);
                chk("bus_wdata", bus_if.o_bus_wdata, v.exp_wdata);
            end else begin
                chk("bus_we_idle", bus_if.o_bus_we, 4'b0000);
                chk("bus_wdata_idle", bus_if.o_bus_wdata, 32'h0);
            end
            chk("done", bus_if.o_done, (n == done_n));
            if (n == done_n) begin
                chk("fault", bus_if.o_fault, (v.exp_cause != 2'b00));
                chk("cause", bus_if.o_fault_cause, v.exp_cause);
                chk("rdata", bus_if.o_rdata, v.exp_rdata);
                last_rdata = v.exp_rdata;
            end else begin
                chk("fault_quiet", bus_if.o_fault, 1'b0);
                chk("cause_quiet", bus_if.o_fault_cause, 2'b00);
                chk("rdata_hold", bus_if.o_rdata, last_rdata);
            end
            bus_if.i_bus_ack = (n <= L) && (n == v.ack_at);
            if (n == done_n && !keep_req) bus_if.i_req = 1'b0;
            #1 chk("busy", bus_if.o_busy, (n <= L));
        end
    endtask

    initial begin
        vec_t v;
        bit   prev_keep;
        n_vec = 0;
        n_err = 0;
        last_rdata = 32'h0;

        //           we    addr          wdata         len    sgn  ack brd           cause  we       wdata         rdata
        tbl[0]  = '{1'b1, 32'h0000_0103, 32'hAABB_CCDD, 2'b00, 1'b0, 1, 32'h0,         2'b00, 4'b1000, 32'hDD00_0000, 32'h0};
        tbl[1]  = '{1'b0, 32'h0000_0202, 32'h0,         2'b01, 1'b1, 1, 32'h8001_1234, 2'b00, 4'b0000, 32'h0,         32'hFFFF_8001};
        tbl[2]  = '{1'b0, 32'h0000_0202, 32'h0,         2'b01, 1'b0, 1, 32'h8001_1234, 2'b00, 4'b0000, 32'h0,         32'h0000_8001};
        tbl[3]  = '{1'b0, 32'h0000_0301, 32'h0,         2'b10, 1'b0, 1, 32'h0,         2'b01, 4'b0000, 32'h0,         32'h0};
        tbl[4]  = '{1'b0, 32'h0000_0000, 32'h0,         2'b11, 1'b0, 1, 32'h0,         2'b11, 4'b0000, 32'h0,         32'h0};
        tbl[5]  = '{1'b1, 32'h0000_0402, 32'h1234_5678, 2'b01, 1'b0, 2, 32'h0,         2'b00, 4'b1100, 32'h5678_0000, 32'h0};
        tbl[6]  = '{1'b0, 32'h0000_0001, 32'h0,         2'b00, 1'b1, 3, 32'h0000_8000, 2'b00, 4'b0000, 32'h0,         32'hFFFF_FF80};
        tbl[7]  = '{1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b0, 0, 32'h5555_5555, 2'b10, 4'b0000, 32'h0,         32'h0};
        tbl[8]  = '{1'b0, 32'h0000_0020, 32'h0,         2'b10, 1'b0, 4, 32'hDEAD_BEEF, 2'b00, 4'b0000, 32'h0,         32'hDEAD_BEEF};
        tbl[9]  = '{1'b1, 32'h0000_0001, 32'h0000_FFFF, 2'b01, 1'b0, 1, 32'h0,         2'b01, 4'b0011, 32'h0,         32'h0};
        tbl[10] = '{1'b1, 32'h0000_0008, 32'h1122_3344, 2'b10, 1'b0, 1, 32'h0,         2'b00, 4'b1111, 32'h1122_3344, 32'h0};
        tbl[11] = '{1'b0, 32'h0000_0000, 32'h0,         2'b01, 1'b1, 1, 32'hFFFF_7FFF, 2'b00, 4'b0000, 32'h0,         32'h0000_7FFF};
        tbl[12] = '{1'b0, 32'h0000_0003, 32'h0,         2'b00, 1'b0, 2, 32'hAB00_0000, 2'b00, 4'b0000, 32'h0,         32'h0000_00AB};
        tbl[13] = '{1'b1, 32'h0000_0002, 32'h0000_00EE, 2'b00, 1'b0, 1, 32'h0,         2'b00, 4'b0100, 32'h00EE_0000, 32'h0};

        rst_n = 1'b0;
        bus_if.i_req = 1'b0;       bus_if.i_we = 1'b0;
        bus_if.i_addr = 32'h0;     bus_if.i_wdata = 32'h0;
        bus_if.i_length = 2'b00;   bus_if.i_signed = 1'b0;
        bus_if.i_bus_ack = 1'b0;   bus_if.i_bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_stb", bus_if.o_bus_stb, 1'b0);
        chk("rst_done", bus_if.o_done, 1'b0);
        chk("rst_busy", bus_if.o_busy, 1'b0);
        chk("rst_fault", bus_if.o_fault, 1'b0);
        chk("rst_cause", bus_if.o_fault_cause, 2'b00);
        chk("rst_rdata", bus_if.o_rdata, 32'h0);
        chk("rst_addr", bus_if.o_bus_addr, 32'h0);
        chk("rst_we", bus_if.o_bus_we, 4'b0000);
        rst_n = 1'b1;

        // directed table
        for (int i = 0; i < 14; i++) run_access(tbl[i], 1'b0, 1'b0);

        // reset while the bus phase is in flight
        @(negedge clk);
        bus_if.i_req = 1'b1; bus_if.i_we = 1'b0; bus_if.i_addr = 32'h0000_0050;
        bus_if.i_length = 2'b10; bus_if.i_bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("midbus_stb", bus_if.o_bus_stb, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("async_stb", bus_if.o_bus_stb, 1'b0);
        bus_if.i_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_rdata = 32'h0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("post_rst_done", bus_if.o_done, 1'b0);
            chk("post_rst_stb", bus_if.o_bus_stb, 1'b0);
        end
        v = '{1'b0, 32'h0000_0060, 32'h0, 2'b10, 1'b0, 1, 32'h1234_5678, 2'b00, 4'b0000, 32'h0, 32'h1234_5678};
        run_access(v, 1'b0, 1'b0);

        // back-to-back store then load with request held high
        v = '{1'b1, 32'h0000_0044, 32'hCAFE_F00D, 2'b10, 1'b0, 1, 32'h0, 2'b00, 4'b1111, 32'hCAFE_F00D, 32'h0};
        run_access(v, 1'b0, 1'b1);
        v = '{1'b0, 32'h0000_0045, 32'h0, 2'b00, 1'b0, 2, 32'h0000_7700, 2'b00, 4'b0000, 32'h0, 32'h0000_0077};
        run_access(v, 1'b1, 1'b0);

        // randomized accesses against the model
        prev_keep = 1'b0;
        for (int i = 0; i < 150; i++) begin
            bit keep;
            v.we     = 1'($urandom_range(0, 1));
            v.len    = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            v.addr   = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (v.len == 2'b01) v.addr[0] = 1'b0;
                if (v.len == 2'b10) v.addr[1:0] = 2'b00;
            end
            v.wdata  = $urandom;
            v.sgn    = 1'($urandom_range(0, 1));
            v.ack_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 6)) : int'($urandom_range(1, 4));
            if ($urandom_range(0, 15) == 0) v.ack_at = 0;
            v.brd    = $urandom;
            v        = model(v);
            keep     = (i != 149) && ($urandom_range(0, 1) == 1);
            run_access(v, prev_keep, keep);
            prev_keep = keep;
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
